// File: rtl/argmax_pkg.sv
// Shared definitions for the argmax / max-unpool pooling datapath.
// Holds the index-width helper and the unpool FSM encoding.
package argmax_pkg;

  // Bit-count of n: log2(4) = 3, log2(5) = 3.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int v = n; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } unpool_state_t;

endpackage

// File: rtl/argmax_unpool.sv
// Max-unpool: expands one (max, ind) pair into an N-element vector,
// streamed one element per beat with max at position ind.
module argmax_unpool
  import argmax_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [M-1:0]         in_max,
  input  logic [log2(N)-1:0]   in_ind,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M-1:0]         out_data,
  output logic [log2(N)-1:0]   out_idx,
  output logic                 out_last,
  output logic                 err
);

  localparam int S = log2(N);
  localparam logic [S-1:0] LAST = S'(N - 1);
  localparam logic [S:0]   NUM  = (S + 1)'(N);

  unpool_state_t  state;
  logic [M-1:0]   max_r;
  logic [S-1:0]   ind_r;
  logic [S-1:0]   idx;

  logic           in_xfer;
  logic           out_beat;
  logic           streaming;

  assign streaming = (state == ST_STREAM);
  assign out_valid = streaming;
  assign out_idx   = idx;
  assign out_last  = streaming && (idx == LAST);
  // An out-of-range ind_r never matches idx, so that vector is all zero.
  assign out_data  = (streaming && (idx == ind_r)) ? max_r : '0;

  // Reload on the final beat keeps vectors back-to-back.
  assign in_ready  = !streaming || (out_ready && out_last);
  assign in_xfer   = in_valid && in_ready;
  assign out_beat  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      max_r <= '0;
      ind_r <= '0;
      idx   <= '0;
      err   <= 1'b0;
    end else if (in_xfer) begin
      state <= ST_STREAM;
      max_r <= in_max;
      ind_r <= in_ind;
      idx   <= '0;
      if ({1'b0, in_ind} >= NUM) begin
        err <= 1'b1;
      end
    end else if (out_beat) begin
      if (out_last) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else begin
        idx   <= idx + S'(1);
      end
    end
  end

endmodule

// File: tb/tb_argmax_unpool.sv
// Scoreboard bench for argmax_unpool (N=4 main instance, N=5 range case).
// Expected beats are queued on each accepted request and popped per beat.
module tb_argmax_unpool;
  import argmax_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] i;
    logic       l;
  } beat_t;

  logic       clk;
  logic       rst;

  logic       in_valid, in_ready;
  logic [7:0] in_max;
  logic [2:0] in_ind;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic       out_last, err;

  logic       iv5, ir5;
  logic [7:0] im5;
  logic [2:0] ii5;
  logic       ov5, or5;
  logic [7:0] od5;
  logic [2:0] oi5;
  logic       ol5, err5;

  int n_vec;
  int n_err;

  beat_t q[$];
  logic       stall;
  logic [7:0] p_data;
  logic [2:0] p_idx;
  logic       p_last;

  argmax_unpool #(.N(4), .M(8)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_max(in_max), .in_ind(in_ind),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .err(err)
  );

  argmax_unpool #(.N(5), .M(8)) u5 (
    .clk(clk), .rst(rst),
    .in_valid(iv5), .in_ready(ir5),
    .in_max(im5), .in_ind(ii5),
    .out_valid(ov5), .out_ready(or5),
    .out_data(od5), .out_idx(oi5),
    .out_last(ol5), .err(err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor and scoreboard for the N=4 instance.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      q.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_data", 32'(out_data), 32'(p_data));
        check("hold_idx",  32'(out_idx),  32'(p_idx));
        check("hold_last", 32'(out_last), 32'(p_last));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_beat", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("beat_data", 32'(out_data), 32'(e.d));
          check("beat_idx",  32'(out_idx),  32'(e.i));
          check("beat_last", 32'(out_last), 32'(e.l));
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < 4; i++) begin
          e.i = 3'(i);
          e.d = (in_ind == 3'(i)) ? in_max : 8'h00;
          e.l = (i == 3);
          q.push_back(e);
        end
      end
      stall  = out_valid && !out_ready;
      p_data = out_data;
      p_idx  = out_idx;
      p_last = out_last;
    end
  end

  initial begin
    logic [3:0] rdy_pat;
    bit         seen;
    n_vec = 0;
    n_err = 0;
    stall = 1'b0;
    p_data = '0;
    p_idx = '0;
    p_last = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0; in_max = '0; in_ind = '0; out_ready = 1'b1;
    iv5 = 1'b0; im5 = '0; ii5 = '0; or5 = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset then idle
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_idx",  32'(out_idx),  32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    for (int c = 0; c < 10; c++) begin
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_ready", 32'(in_ready),  32'd1);
      check("idle_err",   32'(err),       32'd0);
      tick();
    end

    // 2: single request, beats on cycles 1..4
    in_valid = 1'b1; in_max = 8'hA5; in_ind = 3'd2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_idx",   32'(out_idx),   32'(i));
      tick();
    end
    check("single_done", 32'(out_valid), 32'd0);
    check("single_rdy",  32'(in_ready),  32'd1);

    // 3: back-to-back, second accepted on beat 3
    in_valid = 1'b1; in_max = 8'h11; in_ind = 3'd0;
    tick();
    in_max = 8'h22; in_ind = 3'd3;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_idx",   32'(out_idx),   32'(i % 4));
      if (in_valid && in_ready) begin
        check("b2b_acc_idx", 32'(out_idx), 32'd3);
        seen = 1'b1;
      end
      tick();
      if (i == 3) in_valid = 1'b0;
    end
    check("b2b_accepted", 32'(seen), 32'd1);
    check("b2b_done", 32'(out_valid), 32'd0);

    // 4: backpressure 1,0,0,1 during the vector
    in_valid = 1'b1; in_max = 8'h7F; in_ind = 3'd1;
    tick();
    in_valid = 1'b0;
    rdy_pat = 4'b1001;
    for (int c = 0; c < 20 && out_valid; c++) begin
      out_ready = (c < 4) ? rdy_pat[3 - c] : 1'b1;
      tick();
    end
    out_ready = 1'b1;
    check("bp_done", 32'(out_valid), 32'd0);
    check("bp_q_empty", 32'(q.size()), 32'd0);

    // 5: N=5 instance, out-of-range ind
    iv5 = 1'b1; im5 = 8'h33; ii5 = 3'd6;
    tick();
    iv5 = 1'b0;
    check("oor_err", 32'(err5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("oor_valid", 32'(ov5), 32'd1);
      check("oor_idx",   32'(oi5), 32'(i));
      check("oor_data",  32'(od5), 32'd0);
      check("oor_last",  32'(ol5), 32'(i == 4));
      tick();
    end
    check("oor_done", 32'(ov5), 32'd0);
    for (int c = 0; c < 5; c++) tick();
    check("oor_sticky", 32'(err5), 32'd1);
    check("n4_err", 32'(err), 32'd0);

    // 6: reset on beat idx=1
    in_valid = 1'b1; in_max = 8'hC3; in_ind = 3'd1;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (out_valid && out_idx == 3'd1) begin
        rst = 1'b1;
        seen = 1'b1;
      end
      tick();
    end
    check("mid_rst_hit", 32'(seen), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_err5",  32'(err5),      32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_max = 8'h5A; in_ind = 3'd0;
    tick();
    in_valid = 1'b0;
    check("restart_idx", 32'(out_idx), 32'd0);
    check("restart_data", 32'(out_data), 32'h5A);

    for (int c = 0; c < 20 && q.size() != 0; c++) tick();
    check("drain", 32'(q.size()), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
